// File: rtl/led_chase_monitor.sv
// Receive-side checker for the one-hot LED bounce pattern: synchronizes the bus,
// tracks the lit position and direction, and flags illegal steps and stalls.
module led_chase_monitor #(
    parameter int W         = 8,
    parameter int TIMEOUT_W = 21,
    localparam int PW       = ($clog2(W) < 1) ? 1 : $clog2(W)
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic [W-1:0]  iLED,
    input  logic          iCLR,
    output logic [PW-1:0] oPOS,
    output logic          oDIR,
    output logic          oVALID,
    output logic          oSTEP,
    output logic          oERR,
    output logic          oSTALL,
    output logic [7:0]    oBOUNCES
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] LOCK1  = 2'd1;
    localparam logic [1:0] TRACK  = 2'd2;

    localparam logic [W-1:0]  LED_ONE  = W'(1);
    localparam logic [PW:0]   WIDE_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_LAST = PW'(W - 1);
    localparam logic [PW-1:0] POS_PEN  = PW'(W - 2);

    function automatic logic isOneHot(input logic [W-1:0] v);
        return (v != '0) && ((v & (v - LED_ONE)) == '0);
    endfunction

    function automatic logic [PW-1:0] oneHotIdx(input logic [W-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [TIMEOUT_W-1:0] satIncCnt(input logic [TIMEOUT_W-1:0] v);
        return (v == '1) ? v : v + TIMEOUT_W'(1);
    endfunction

    logic [W-1:0]          ledSync1, ledSync2, ledPrev;
    logic [1:0]            state, stateNext;
    logic [PW-1:0]         posNext, expPos, ledIdx;
    logic                  dirNext, stepNext, errEvt, bounceEvt, expRev;
    logic                  change, ledHot, adjacent;
    logic                  errNext;
    logic [7:0]            bouncesBase, bouncesNext;
    logic [TIMEOUT_W-1:0]  stallCnt, stallCntNext;

    // Decode of the synchronized bus and the position the bounce should visit next
    always_comb begin
        change   = (ledSync2 != ledPrev);
        ledHot   = isOneHot(ledSync2);
        ledIdx   = oneHotIdx(ledSync2);
        adjacent = ({1'b0, ledIdx} == {1'b0, oPOS} + WIDE_ONE) ||
                   ({1'b0, ledIdx} + WIDE_ONE == {1'b0, oPOS});
        expRev   = 1'b0;
        if (oDIR) begin
            if (oPOS == '0) begin
                expPos = POS_ONE;
                expRev = 1'b1;
            end else begin
                expPos = oPOS - POS_ONE;
            end
        end else begin
            if (oPOS == POS_LAST) begin
                expPos = POS_PEN;
                expRev = 1'b1;
            end else begin
                expPos = oPOS + POS_ONE;
            end
        end
    end

    always_comb begin
        stateNext = state;
        posNext   = oPOS;
        dirNext   = oDIR;
        stepNext  = 1'b0;
        errEvt    = 1'b0;
        bounceEvt = 1'b0;
        if (change) begin
            case (state)
                SEARCH: begin
                    if (ledHot) begin
                        stateNext = LOCK1;
                        posNext   = ledIdx;
                    end
                end
                LOCK1: begin
                    if (ledHot && adjacent) begin
                        stateNext = TRACK;
                        posNext   = ledIdx;
                        dirNext   = (ledIdx < oPOS);
                        stepNext  = 1'b1;
                    end else if (ledHot) begin
                        errEvt    = 1'b1;
                        posNext   = ledIdx;
                    end else begin
                        errEvt    = 1'b1;
                        stateNext = SEARCH;
                    end
                end
                TRACK: begin
                    if (ledHot && (ledIdx == expPos)) begin
                        posNext   = ledIdx;
                        stepNext  = 1'b1;
                        if (expRev) begin
                            bounceEvt = 1'b1;
                            dirNext   = ~oDIR;
                        end
                    end else if (ledHot) begin
                        errEvt    = 1'b1;
                        stateNext = LOCK1;
                        posNext   = ledIdx;
                    end else begin
                        errEvt    = 1'b1;
                        stateNext = SEARCH;
                    end
                end
                default: stateNext = SEARCH;
            endcase
        end
        if (stateNext != TRACK) dirNext = 1'b0;
    end

    // Clear is applied before the same-cycle event so that the event survives it
    always_comb begin
        errNext     = (iCLR ? 1'b0 : oERR) | errEvt;
        bouncesBase = iCLR ? 8'd0 : oBOUNCES;
        bouncesNext = bounceEvt ? satInc8(bouncesBase) : bouncesBase;
        if ((state == SEARCH) || change || iCLR) begin
            stallCntNext = '0;
        end else begin
            stallCntNext = satIncCnt(stallCnt);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ledSync1 <= '0;
            ledSync2 <= '0;
            ledPrev  <= '0;
            state    <= SEARCH;
            stallCnt <= '0;
            oPOS     <= '0;
            oDIR     <= 1'b0;
            oVALID   <= 1'b0;
            oSTEP    <= 1'b0;
            oERR     <= 1'b0;
            oSTALL   <= 1'b0;
            oBOUNCES <= 8'd0;
        end else begin
            ledSync1 <= iLED;
            ledSync2 <= ledSync1;
            ledPrev  <= ledSync2;
            state    <= stateNext;
            stallCnt <= stallCntNext;
            oPOS     <= posNext;
            oDIR     <= dirNext;
            oVALID   <= (stateNext != SEARCH);
            oSTEP    <= stepNext;
            oERR     <= errNext;
            oSTALL   <= (stallCntNext == '1);
            oBOUNCES <= bouncesNext;
        end
    end

endmodule

// File: tb/tb_led_chase_monitor.sv
// Directed bench for led_chase_monitor: lock, bounce tracking, error recovery,
// stall detection, clear priority and asynchronous reset.
module tb_led_chase_monitor;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic       iCLR;
    logic [7:0] iLED;
    logic [2:0] oPOS;
    logic       oDIR, oVALID, oSTEP, oERR, oSTALL;
    logic [7:0] oBOUNCES;

    int checks   = 0;
    int failures = 0;
    int stepCnt  = 0;

    led_chase_monitor #(.W(8), .TIMEOUT_W(4)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iLED(iLED), .iCLR(iCLR),
        .oPOS(oPOS), .oDIR(oDIR), .oVALID(oVALID), .oSTEP(oSTEP),
        .oERR(oERR), .oSTALL(oSTALL), .oBOUNCES(oBOUNCES)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oSTEP === 1'b1) stepCnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Outputs reflect a new bus value on the third edge after it is driven
    task automatic drive(input logic [7:0] v);
        iLED = v;
        repeat (3) tick();
    endtask

    logic [7:0] seq [13] = '{8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04,
                              8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};

    initial begin
        iRST_N = 1'b0;
        iCLR   = 1'b0;
        iLED   = 8'h80;
        repeat (3) tick();
        chk("rst_pos", 32'(oPOS), 0);
        chk("rst_dir", 32'(oDIR), 0);
        chk("rst_valid", 32'(oVALID), 0);
        chk("rst_step", 32'(oSTEP), 0);
        chk("rst_err", 32'(oERR), 0);
        chk("rst_bounces", 32'(oBOUNCES), 0);
        chk("rst_stall", 32'(oSTALL), 0);

        iRST_N = 1'b1;
        repeat (3) tick();
        chk("lock_valid", 32'(oVALID), 1);
        chk("lock_pos", 32'(oPOS), 7);
        chk("lock_step", 32'(oSTEP), 0);
        chk("lock_dir", 32'(oDIR), 0);

        repeat (14) tick();
        chk("stall_pre", 32'(oSTALL), 0);
        tick();
        chk("stall_set", 32'(oSTALL), 1);

        iLED = 8'h40;
        tick();
        tick();
        chk("stall_hold", 32'(oSTALL), 1);
        tick();
        chk("step40_step", 32'(oSTEP), 1);
        chk("step40_pos", 32'(oPOS), 6);
        chk("step40_dir", 32'(oDIR), 1);
        chk("step40_stall", 32'(oSTALL), 0);
        tick();
        chk("step40_pulse", 32'(oSTEP), 0);
        repeat (12) tick();

        drive(8'h20);
        chk("step20_step", 32'(oSTEP), 1);
        chk("step20_pos", 32'(oPOS), 5);
        chk("step20_dir", 32'(oDIR), 1);
        chk("step20_err", 32'(oERR), 0);
        repeat (13) tick();

        foreach (seq[i]) begin
            drive(seq[i]);
            tick();
        end
        chk("bounce_cnt", 32'(oBOUNCES), 2);
        chk("bounce_pos", 32'(oPOS), 6);
        chk("bounce_dir", 32'(oDIR), 1);
        chk("bounce_err", 32'(oERR), 0);
        chk("bounce_steps", 32'(stepCnt), 15);

        drive(8'h20);
        tick();
        drive(8'h04);
        chk("skip_err", 32'(oERR), 1);
        chk("skip_valid", 32'(oVALID), 1);
        chk("skip_pos", 32'(oPOS), 2);
        chk("skip_step", 32'(oSTEP), 0);
        chk("skip_dir", 32'(oDIR), 0);
        tick();
        drive(8'h02);
        chk("relock_step", 32'(oSTEP), 1);
        chk("relock_dir", 32'(oDIR), 1);
        chk("relock_pos", 32'(oPOS), 1);
        chk("relock_err", 32'(oERR), 1);
        tick();

        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        chk("clr_err", 32'(oERR), 0);
        chk("clr_bounces", 32'(oBOUNCES), 0);

        drive(8'h18);
        chk("multi_err", 32'(oERR), 1);
        chk("multi_valid", 32'(oVALID), 0);
        chk("multi_dir", 32'(oDIR), 0);
        chk("multi_pos", 32'(oPOS), 1);
        tick();
        drive(8'h08);
        chk("search_valid", 32'(oVALID), 1);
        chk("search_pos", 32'(oPOS), 3);
        chk("search_step", 32'(oSTEP), 0);
        tick();
        drive(8'h04);
        chk("track_step", 32'(oSTEP), 1);
        chk("track_dir", 32'(oDIR), 1);
        chk("track_pos", 32'(oPOS), 2);
        tick();

        drive(8'h02);
        tick();
        drive(8'h01);
        tick();
        drive(8'h02);
        chk("rev_bounces", 32'(oBOUNCES), 1);
        chk("rev_dir", 32'(oDIR), 0);
        tick();

        iLED = 8'h40;
        tick();
        tick();
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        chk("clrerr_err", 32'(oERR), 1);
        chk("clrerr_bounces", 32'(oBOUNCES), 0);
        chk("clrerr_valid", 32'(oVALID), 1);
        chk("clrerr_pos", 32'(oPOS), 6);
        chk("clrerr_step", 32'(oSTEP), 0);
        tick();

        drive(8'h20);
        chk("pre_rst_step", 32'(oSTEP), 1);
        chk("pre_rst_valid", 32'(oVALID), 1);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("arst_pos", 32'(oPOS), 0);
        chk("arst_valid", 32'(oVALID), 0);
        chk("arst_dir", 32'(oDIR), 0);
        chk("arst_step", 32'(oSTEP), 0);
        chk("arst_err", 32'(oERR), 0);
        chk("arst_bounces", 32'(oBOUNCES), 0);
        chk("arst_stall", 32'(oSTALL), 0);
        tick();
        iRST_N = 1'b1;
        repeat (3) tick();
        chk("resume_valid", 32'(oVALID), 1);
        chk("resume_pos", 32'(oPOS), 5);
        chk("resume_err", 32'(oERR), 0);
        chk("resume_step", 32'(oSTEP), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_chase_monitor.md
# led_chase_monitor

Receive-side checker for the 8-LED bounce ("chaser") pattern on the board's LED bus. It samples the one-hot LED vector, decodes the lit position and travel direction, and confirms that every step matches the bounce sequence. Illegal steps, malformed patterns and stalls are flagged. It sits beside the chaser as a self-check and as a position source for other logic.

## Interface
- W, 8 — LED bus width; W >= 2.
- TIMEOUT_W, 21 — stall counter width; the stall limit is 2^TIMEOUT_W-1 cycles.
- iCLK  in  1  — system clock; all logic on the rising edge.
- iRST_N  in  1  — reset, asynchronous, active-low.
- iLED  in  W  — LED bus; may be asynchronous to iCLK.
- iCLR  in  1  — synchronous clear of oERR, oBOUNCES and the stall counter. Does not change state.
- oPOS  out  max(1,clog2(W))  — index of the lit LED.
- oDIR  out  1  — 1 = moving toward bit 0, 0 = moving toward bit W-1. Meaningful only in TRACK.
- oVALID  out  1  — high in LOCK1 and TRACK.
- oSTEP  out  1  — one-cycle pulse per legal step.
- oERR  out  1  — sticky error flag.
- oSTALL  out  1  — no change event for the stall limit while locked.
- oBOUNCES  out  8  — count of end reversals; saturates at 255.

## Operation
- Input path: iLED → sync1 → sync2, a 2-flop synchronizer. A change event occurs when sync2 != prev. prev <= sync2 every cycle.
- Expected next position from pos/dir:
  - dir=1: 1 if pos==0 (reversal, dir flips to 0), otherwise pos-1.
  - dir=0: W-2 if pos==W-1 (reversal, dir flips to 1), otherwise pos+1.
- SEARCH (reset state)
  - One-hot change event → LOCK1, pos=index. No oSTEP.
  - Non-one-hot values are ignored. No error.
- LOCK1
  - Adjacent one-hot → TRACK, oSTEP pulse. dir=1 if new index < pos, else 0.
  - Non-adjacent one-hot → oERR=1, stay in LOCK1 with pos=new index.
  - Non-one-hot → oERR=1, go to SEARCH.
- TRACK
  - Index equal to the expected position → oSTEP pulse, pos updated. A reversal also increments oBOUNCES (saturating) and flips dir.
  - Other one-hot → oERR=1, go to LOCK1 with pos=new index, no oSTEP.
  - Non-one-hot (including 0) → oERR=1, go to SEARCH.
- Stall counter
  - Held at 0 in SEARCH.
  - In LOCK1/TRACK: cleared on a change event, otherwise increments and saturates at all-ones.
  - oSTALL = (counter == all-ones).
- iCLR: oERR, oBOUNCES and the stall counter are cleared first; any same-cycle event then applies. So a same-cycle error leaves oERR=1, and a same-cycle reversal leaves oBOUNCES=1.
- Output values:
  - oVALID=0 in SEARCH; oPOS holds its last value.
  - oDIR is forced to 0 outside TRACK.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state=SEARCH, sync1/sync2/prev/counters = 0.
- Latency: let edge k be the first edge at which sync1 captures a new iLED value.
  - oPOS, oDIR, oVALID, oSTEP, oERR and oBOUNCES update at edge k+2.
  - oSTEP is high for exactly one cycle.
- oSTALL rises at the edge on which the counter reaches all-ones, i.e. 2^TIMEOUT_W-1 cycles after the last change event. It falls at the edge of the next change event (the k+2 edge).
- iLED values held for fewer than 2 cycles are not guaranteed to be seen. The bench holds each value for at least 3 cycles.
- Asserting iRST_N low mid-operation forces reset values immediately. Operation resumes from SEARCH after release.

## Test plan
- Reset with iLED=0x80, then 0x40, 0x20, each held 16 cycles:
  - Three cycles after 0x80 is first sampled: oVALID=1, oPOS=7, no oSTEP.
  - Then oSTEP pulses with oDIR=1 and oPOS=6, then oPOS=5.
  - oERR=0 throughout.
- Drive 80→40→…→01→02→…→80→40:
  - oBOUNCES=2, final oPOS=6, oDIR=1, oERR=0.
  - 15 oSTEP pulses in total.
- While tracking at 0x20 (dir=1), drive 0x04:
  - oERR=1, oVALID=1, oPOS=2, no oSTEP.
  - Then 0x02: oSTEP, oDIR=1, oERR stays 1.
- While tracking, drive 0x18:
  - oERR=1, oVALID=0.
  - Then 0x08: oVALID=1, oPOS=3.
  - Then 0x04: oSTEP, oDIR=1.
- TIMEOUT_W=4, lock at 0x80, hold 15 cycles:
  - oSTALL=1.
  - Drive 0x40: oSTALL=0 at the k+2 edge, with oSTEP.
- iCLR in the same cycle as an illegal-step update → oERR=1, oBOUNCES=0.
- Assert iRST_N low mid-TRACK → all outputs 0 immediately, without waiting for an iCLK edge.
